decade_load_arbiter: RTL and testbench

- Shares one loadable decade counter (Load/Enable/P/Q datapath, count 0-9) between N_REQ requesters.
- Each requester asks to preset the counter to its own value.
- The block grants requesters round-robin, sequences the counter's load, checks that Q equals the requested value one cycle after the load, and returns a one-cycle ack (load verified) or nack (rejected or mismatched).
- It sits between requesting control logic and the counter, and owns the counter's Load/Enable/P pins.

---
 rtl/decade_load_arbiter_if.sv | 33 +++
 rtl/decade_load_arbiter.sv | 156 +++++++++++++++
 tb/tb_decade_load_arbiter.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/decade_load_arbiter_if.sv
// Bundle of request, counter and status signals around the decade load arbiter.
// The master side is the requester/counter environment, the slave side is the
// arbiter itself.
`timescale 1ns/1ps
interface decade_load_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int W     = 4
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]   req;
  logic [N_REQ*W-1:0] load_val;
  logic               run_en;
  logic [W-1:0]       cnt_q;
  logic               cnt_load;
  logic               cnt_enable;
  logic [W-1:0]       cnt_p;
  logic [N_REQ-1:0]   ack;
  logic [N_REQ-1:0]   nack;
  logic [IW-1:0]      grant_idx;
  logic               busy;
  logic               err_sticky;

  modport master (
    output req, load_val, run_en, cnt_q,
    input  cnt_load, cnt_enable, cnt_p, ack, nack, grant_idx, busy, err_sticky
  );

  modport slave (
    input  req, load_val, run_en, cnt_q,
    output cnt_load, cnt_enable, cnt_p, ack, nack, grant_idx, busy, err_sticky
  );
endinterface

// File: rtl/decade_load_arbiter.sv
// Round-robin arbiter sharing one loadable decade counter between N_REQ
// requesters: presets the counter, verifies Q one cycle later and answers
// each requester with a one-cycle ack (verified) or nack (rejected/mismatch).
`timescale 1ns/1ps
module decade_load_arbiter #(
  parameter int N_REQ    = 4,
  parameter int W        = 4,
  parameter int MAX_VAL  = 9,
  parameter int CHECK_EN = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  decade_load_arbiter_if.slave     bus
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]       state_reg;
  logic [IW-1:0]    rr_ptr_reg;
  logic [IW-1:0]    grant_reg;
  logic [W-1:0]     val_reg;
  logic             cnt_load_reg;
  logic [W-1:0]     cnt_p_reg;
  logic [N_REQ-1:0] ack_reg;
  logic [N_REQ-1:0] nack_reg;
  logic             busy_reg;
  logic             err_reg;

  // Per-requester view of the packed load value bus.
  logic [W-1:0]     val_arr [N_REQ];

  // Round-robin selection results.
  logic             sel_any;
  logic [IW-1:0]    sel_idx;
  logic [W-1:0]     sel_val;
  logic             sel_oor;
  logic [IW-1:0]    cand;
  int               pos;

  // Derived values for the registered outputs.
  logic [N_REQ-1:0] grant_onehot;
  logic [IW-1:0]    rr_ptr_next;
  logic             q_ok;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_val
      assign val_arr[gi] = bus.load_val[gi*W +: W];
    end
  endgenerate

  // First set request searching upward from rr_ptr with wrap; the loop runs
  // from the farthest offset down so the nearest requester is assigned last.
  always_comb begin
    sel_any = |bus.req;
    sel_idx = '0;
    cand    = '0;
    pos     = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      pos = int'(rr_ptr_reg) + k;
      if (pos >= N_REQ) begin
        pos = pos - N_REQ;
      end
      cand = IW'(pos);
      if (bus.req[cand]) begin
        sel_idx = cand;
      end
    end
  end

  assign sel_val = val_arr[sel_idx];
  // Compare in 32 bits so a MAX_VAL wider than W simply never rejects.
  assign sel_oor = (32'(sel_val) > 32'(MAX_VAL));

  assign grant_onehot = N_REQ'(1) << grant_reg;
  assign rr_ptr_next  = (grant_reg == IW'(N_REQ - 1)) ? '0 : grant_reg + 1'b1;
  assign q_ok         = (CHECK_EN == 0) || (bus.cnt_q == val_reg);

  // Arbitration FSM with all registered outputs; ack/nack/load are pulses.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      rr_ptr_reg   <= '0;
      grant_reg    <= '0;
      val_reg      <= '0;
      cnt_load_reg <= 1'b0;
      cnt_p_reg    <= '0;
      ack_reg      <= '0;
      nack_reg     <= '0;
      busy_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      cnt_load_reg <= 1'b0;
      cnt_p_reg    <= '0;
      ack_reg      <= '0;
      nack_reg     <= '0;
      case (state_reg)
        IDLE: begin
          if (sel_any) begin
            grant_reg <= sel_idx;
            val_reg   <= sel_val;
            busy_reg  <= 1'b1;
            if (sel_oor) begin
              // Out-of-range value: answer at once, counter untouched.
              nack_reg  <= N_REQ'(1) << sel_idx;
              state_reg <= DONE;
            end else begin
              cnt_load_reg <= 1'b1;
              cnt_p_reg    <= sel_val;
              state_reg    <= LOAD;
            end
          end
        end
        LOAD: begin
          // The counter takes P on the edge leaving this state.
          state_reg <= CHECK;
        end
        CHECK: begin
          if (q_ok) begin
            ack_reg <= grant_onehot;
          end else begin
            nack_reg <= grant_onehot;
            err_reg  <= 1'b1;
          end
          state_reg <= DONE;
        end
        DONE: begin
          // The served requester drops to lowest priority next round.
          rr_ptr_reg <= rr_ptr_next;
          busy_reg   <= 1'b0;
          state_reg  <= IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.cnt_load   = cnt_load_reg;
  assign bus.cnt_p      = cnt_p_reg;
  assign bus.ack        = ack_reg;
  assign bus.nack       = nack_reg;
  assign bus.grant_idx  = grant_reg;
  assign bus.busy       = busy_reg;
  assign bus.err_sticky = err_reg;
  // Free-run enable passes through only while no load is in flight.
  assign bus.cnt_enable = (state_reg == IDLE) && bus.run_en;

endmodule

// File: tb/tb_decade_load_arbiter.sv
// Directed bench for decade_load_arbiter: table of single-request vectors,
// plus sequences for round robin, Q mismatch, run_en gating and mid-load reset.
`timescale 1ns/1ps
module tb_decade_load_arbiter;

  logic clk;
  logic reset_n;
  logic defect1;
  logic [3:0] q1;
  logic [3:0] q2;
  int n_cmp;
  int n_bad;

  decade_load_arbiter_if #(.N_REQ(4), .W(4)) bus ();
  decade_load_arbiter_if #(.N_REQ(4), .W(4)) bus2 ();

  decade_load_arbiter #(.N_REQ(4), .W(4), .MAX_VAL(9), .CHECK_EN(1)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  // Second instance with checking disabled, fed the same requests but a
  // counter that always loads P+1.
  decade_load_arbiter #(.N_REQ(4), .W(4), .MAX_VAL(9), .CHECK_EN(0)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(bus2)
  );

  assign bus2.req      = bus.req;
  assign bus2.load_val = bus.load_val;
  assign bus2.run_en   = bus.run_en;
  assign bus.cnt_q     = q1;
  assign bus2.cnt_q    = q2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decade counter model; defect1 emulates a counter that loads P+1.
  always_ff @(posedge clk) begin
    if (!reset_n) q1 <= 4'd0;
    else if (bus.cnt_load) q1 <= defect1 ? bus.cnt_p + 4'd1 : bus.cnt_p;
    else if (bus.cnt_enable) q1 <= (q1 == 4'd9) ? 4'd0 : q1 + 4'd1;
  end

  // Always-defective counter for the unchecked instance.
  always_ff @(posedge clk) begin
    if (!reset_n) q2 <= 4'd0;
    else if (bus2.cnt_load) q2 <= bus2.cnt_p + 4'd1;
    else if (bus2.cnt_enable) q2 <= (q2 == 4'd9) ? 4'd0 : q2 + 4'd1;
  end

  typedef struct {
    logic [3:0]  req;
    logic [15:0] lv;
    logic [3:0]  exp_ack;
    logic [3:0]  exp_nack;
    logic [1:0]  exp_idx;
    logic [3:0]  exp_p;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // One isolated request from IDLE; the edge after driving req is E0.
  task automatic run_vec(input vec_t v, input int n);
    bus.req = v.req;
    bus.load_val = v.lv;
    tick();
    chk($sformatf("v%0d busy", n), 32'(bus.busy), 32'd1);
    chk($sformatf("v%0d grant_idx", n), 32'(bus.grant_idx), 32'(v.exp_idx));
    if (v.exp_ack == 4'd0) begin
      chk($sformatf("v%0d nack_oor", n), 32'(bus.nack), 32'(v.exp_nack));
      chk($sformatf("v%0d ack_oor", n), 32'(bus.ack), 32'd0);
      chk($sformatf("v%0d no_load", n), 32'(bus.cnt_load), 32'd0);
      bus.req = 4'd0;
      tick();
      chk($sformatf("v%0d nack_end", n), 32'(bus.nack), 32'd0);
      chk($sformatf("v%0d idle", n), 32'(bus.busy), 32'd0);
    end else begin
      chk($sformatf("v%0d cnt_load", n), 32'(bus.cnt_load), 32'd1);
      chk($sformatf("v%0d cnt_p", n), 32'(bus.cnt_p), 32'(v.exp_p));
      tick();
      chk($sformatf("v%0d load_pulse", n), 32'(bus.cnt_load), 32'd0);
      chk($sformatf("v%0d early_ack", n), 32'(bus.ack), 32'd0);
      tick();
      chk($sformatf("v%0d ack", n), 32'(bus.ack), 32'(v.exp_ack));
      chk($sformatf("v%0d nack", n), 32'(bus.nack), 32'd0);
      bus.req = 4'd0;
      tick();
      chk($sformatf("v%0d ack_end", n), 32'(bus.ack), 32'd0);
      chk($sformatf("v%0d idle", n), 32'(bus.busy), 32'd0);
    end
    chk($sformatf("v%0d err", n), 32'(bus.err_sticky), 32'd0);
    $display("vec %0d req=%b val=%h ack=%b nack=%b idx=%0d", n, v.req, v.lv, v.exp_ack, v.exp_nack, v.exp_idx);
  endtask

  initial begin
    int ack_cyc [4];
    int ack_idx [4];
    int n_acks;

    n_cmp = 0;
    n_bad = 0;
    defect1 = 1'b0;
    reset_n = 1'b0;
    bus.req = 4'd0;
    bus.load_val = 16'd0;
    bus.run_en = 1'b0;

    vecs[0] = '{req: 4'b0010, lv: 16'h0070, exp_ack: 4'b0010, exp_nack: 4'b0000, exp_idx: 2'd1, exp_p: 4'd7};
    vecs[1] = '{req: 4'b0100, lv: 16'h0C00, exp_ack: 4'b0000, exp_nack: 4'b0100, exp_idx: 2'd2, exp_p: 4'd0};
    vecs[2] = '{req: 4'b0001, lv: 16'h5550, exp_ack: 4'b0001, exp_nack: 4'b0000, exp_idx: 2'd0, exp_p: 4'd0};
    vecs[3] = '{req: 4'b1000, lv: 16'h9000, exp_ack: 4'b1000, exp_nack: 4'b0000, exp_idx: 2'd3, exp_p: 4'd9};
    vecs[4] = '{req: 4'b1000, lv: 16'hA999, exp_ack: 4'b0000, exp_nack: 4'b1000, exp_idx: 2'd3, exp_p: 4'd0};
    vecs[5] = '{req: 4'b0001, lv: 16'h000F, exp_ack: 4'b0000, exp_nack: 4'b0001, exp_idx: 2'd0, exp_p: 4'd0};

    // Reset state, checked while reset is still asserted.
    tick();
    tick();
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst cnt_load", 32'(bus.cnt_load), 32'd0);
    chk("rst cnt_p", 32'(bus.cnt_p), 32'd0);
    chk("rst ack", 32'(bus.ack), 32'd0);
    chk("rst nack", 32'(bus.nack), 32'd0);
    chk("rst grant_idx", 32'(bus.grant_idx), 32'd0);
    chk("rst err", 32'(bus.err_sticky), 32'd0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], i);
    end

    // Round robin: req=1011 held from rr_ptr=0, req0 re-raised after idx 3.
    do_reset();
    tick();
    bus.load_val = 16'h8052;
    bus.req = 4'b1011;
    n_acks = 0;
    for (int c = 1; c <= 18; c++) begin
      tick();
      if (bus.ack != 4'd0) begin
        if (n_acks < 4) begin
          ack_cyc[n_acks] = c;
          ack_idx[n_acks] = int'(bus.grant_idx);
        end
        n_acks++;
        $display("rr cycle %0d ack=%b idx=%0d", c, bus.ack, bus.grant_idx);
        chk("rr ack_vs_idx", 32'(bus.ack), 32'(4'b0001 << bus.grant_idx));
        bus.req = bus.req & ~bus.ack;
        if (bus.ack[3]) bus.req[0] = 1'b1;
      end
      chk("rr no_nack", 32'(bus.nack), 32'd0);
    end
    chk("rr ack_count", 32'(n_acks), 32'd4);
    if (n_acks == 4) begin
      chk("rr idx0", 32'(ack_idx[0]), 32'd0);
      chk("rr idx1", 32'(ack_idx[1]), 32'd1);
      chk("rr idx2", 32'(ack_idx[2]), 32'd3);
      chk("rr idx3", 32'(ack_idx[3]), 32'd0);
      chk("rr first_ack", 32'(ack_cyc[0]), 32'd3);
      chk("rr gap1", 32'(ack_cyc[1] - ack_cyc[0]), 32'd4);
      chk("rr gap2", 32'(ack_cyc[2] - ack_cyc[1]), 32'd4);
      chk("rr gap3", 32'(ack_cyc[3] - ack_cyc[2]), 32'd4);
    end
    bus.req = 4'd0;
    tick();

    // Counter loads P+1: checked instance nacks and sets err, unchecked acks.
    defect1 = 1'b1;
    bus.load_val = 16'h0003;
    bus.req = 4'b0001;
    tick();
    chk("def cnt_p", 32'(bus.cnt_p), 32'd3);
    tick();
    chk("def cnt_q", 32'(bus.cnt_q), 32'd4);
    tick();
    chk("def nack", 32'(bus.nack), 32'b0001);
    chk("def ack", 32'(bus.ack), 32'd0);
    chk("def err", 32'(bus.err_sticky), 32'd1);
    chk("nochk ack", 32'(bus2.ack), 32'b0001);
    chk("nochk nack", 32'(bus2.nack), 32'd0);
    chk("nochk err", 32'(bus2.err_sticky), 32'd0);
    $display("defect load 3 q=%0d nack=%b ack2=%b", bus.cnt_q, bus.nack, bus2.ack);
    bus.req = 4'd0;
    tick();
    defect1 = 1'b0;

    // run_en forwarded only in IDLE; a good load leaves err_sticky set.
    bus.run_en = 1'b1;
    tick();
    chk("run idle en", 32'(bus.cnt_enable), 32'd1);
    bus.load_val = 16'h0600;
    bus.req = 4'b0100;
    tick();
    chk("run load en", 32'(bus.cnt_enable), 32'd0);
    tick();
    chk("run check en", 32'(bus.cnt_enable), 32'd0);
    tick();
    chk("run done en", 32'(bus.cnt_enable), 32'd0);
    chk("run ack", 32'(bus.ack), 32'b0100);
    chk("err held", 32'(bus.err_sticky), 32'd1);
    bus.req = 4'd0;
    tick();
    chk("run back en", 32'(bus.cnt_enable), 32'd1);
    bus.run_en = 1'b0;
    $display("run_en gating done, rr_ptr now 3");

    // Reset during LOAD drops the transaction and clears rr_ptr and err.
    bus.load_val = 16'h4000;
    bus.req = 4'b1000;
    tick();
    chk("mid cnt_load", 32'(bus.cnt_load), 32'd1);
    reset_n = 1'b0;
    bus.req = 4'd0;
    tick();
    chk("mid busy", 32'(bus.busy), 32'd0);
    chk("mid cnt_load0", 32'(bus.cnt_load), 32'd0);
    chk("mid err", 32'(bus.err_sticky), 32'd0);
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("mid no_resp", 32'(bus.ack | bus.nack), 32'd0);
    end
    bus.load_val = 16'h2001;
    bus.req = 4'b1001;
    tick();
    chk("mid rr_ptr0", 32'(bus.grant_idx), 32'd0);
    tick();
    tick();
    chk("mid post_ack", 32'(bus.ack), 32'b0001);
    bus.req = 4'd0;
    tick();
    $display("mid-load reset sequence done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
